// File: rtl/nv_nvdla_pdp_core_cal2d_pipe_unpack.sv
// Receiving end of the cal2d d4 pipe: holds one wide bundle and drains it
// downstream as BEATS narrow beats, lowest slice first.
module nv_nvdla_pdp_core_cal2d_pipe_unpack #(
  parameter int IN_W   = 255,
  parameter int OUT_W  = 64,
  localparam int BEATS = (IN_W + OUT_W - 1) / OUT_W,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             nvdla_op_gated_clk_fp16,
  input  logic             nvdla_core_rst,
  input  logic             din_vld_d4,
  output logic             din_rdy_d4,
  input  logic [IN_W-1:0]  din_pd_d4,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [OUT_W-1:0] dout_pd,
  output logic [CW-1:0]    dout_idx,
  output logic             dout_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [IN_W-1:0]        r_buf_pd;
  logic                   r_buf_vld;
  logic [CW-1:0]          r_cnt;

  logic                   w_on_last;
  logic                   w_in_acc;
  logic                   w_beat_acc;
  logic [BEATS*OUT_W-1:0] w_pad;

  assign w_on_last  = (r_cnt == LAST_IDX);
  // Ready looks through to dout_rdy on the last beat so bundles stream without a bubble.
  assign din_rdy_d4 = !r_buf_vld || (dout_rdy && w_on_last);
  assign w_in_acc   = din_vld_d4 && din_rdy_d4;
  assign w_beat_acc = r_buf_vld && dout_rdy;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_pad             = '0;
    w_pad[IN_W-1:0]   = r_buf_pd;
  end

  assign dout_pd   = w_pad[r_cnt*OUT_W +: OUT_W];
  assign dout_vld  = r_buf_vld;
  assign dout_idx  = r_cnt;
  assign dout_last = r_buf_vld && w_on_last;

  // NOTE: sequential state uses non-blocking assignments; the wide holding register is
  // reset too so dout_pd reads zero during and right after reset.
  always_ff @(posedge nvdla_op_gated_clk_fp16 or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_buf_pd  <= '0;
      r_buf_vld <= 1'b0;
      r_cnt     <= '0;
    end else if (w_in_acc) begin
      r_buf_pd  <= din_pd_d4;
      r_buf_vld <= 1'b1;
      r_cnt     <= '0;
    end else if (w_beat_acc && w_on_last) begin
      r_buf_vld <= 1'b0;
      r_cnt     <= '0;
    end else if (w_beat_acc) begin
      r_cnt     <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_core_cal2d_pipe_unpack.sv
// Scoreboard bench for the cal2d unpack stage: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_nv_nvdla_pdp_core_cal2d_pipe_unpack;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_vld = 1'b0;
  logic         din_rdy;
  logic [254:0] din_pd = '0;
  logic         dout_vld;
  logic         dout_rdy = 1'b0;
  logic [63:0]  dout_pd;
  logic [1:0]   dout_idx;
  logic         dout_last;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] pd;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  nv_nvdla_pdp_core_cal2d_pipe_unpack dut (
    .nvdla_op_gated_clk_fp16 (clk),
    .nvdla_core_rst          (rst),
    .din_vld_d4              (din_vld),
    .din_rdy_d4              (din_rdy),
    .din_pd_d4               (din_pd),
    .dout_vld                (dout_vld),
    .dout_rdy                (dout_rdy),
    .dout_pd                 (dout_pd),
    .dout_idx                (dout_idx),
    .dout_last               (dout_last)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, elapsed %0t, required end before 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a bundle built from four hand-chosen words (w3 bit 63 must be 0).
  task automatic load(input logic [63:0] w0, input logic [63:0] w1,
                      input logic [63:0] w2, input logic [63:0] w3);
    din_pd  = {w3[62:0], w2, w1, w0};
    din_vld = 1'b1;
    exp_q.push_back('{w0, 2'd0, 1'b0});
    exp_q.push_back('{w1, 2'd1, 1'b0});
    exp_q.push_back('{w2, 2'd2, 1'b0});
    exp_q.push_back('{w3, 2'd3, 1'b1});
  endtask

  // Wait (bounded) for din_rdy, then step past the accepting edge.
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (din_rdy) ok = 1'b1;
    end
    check({name, "_accept"}, 64'(ok), 64'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got pd %h idx %0d, expected no beat", dout_pd, dout_idx);
      end else begin
        e = exp_q.pop_front();
        check("beat_pd", dout_pd, e.pd);
        check("beat_idx", 64'(dout_idx), 64'(e.idx));
        check("beat_last", 64'(dout_last), 64'(e.last));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_vld", 64'(dout_vld), 64'd0);
    check("reset_pd", dout_pd, 64'd0);
    check("reset_rdy", 64'(din_rdy), 64'd1);
    check("reset_idx", 64'(dout_idx), 64'd0);
    check("reset_last", 64'(dout_last), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dout_rdy = 1'b1;

    // Single bundle with bit 254 set; top beat carries it as bit 62
    load(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
         64'hCCCC_CCCC_CCCC_CCCC, 64'h4000_0000_0000_0000);
    wait_accept("single");
    din_vld = 1'b0;
    @(negedge clk);
    check("latency_vld", 64'(dout_vld), 64'd1);
    check("latency_idx", 64'(dout_idx), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("single_idle_vld", 64'(dout_vld), 64'd0);
    dout_rdy = 1'b0;
    #1;
    check("empty_rdy_no_dout_rdy", 64'(din_rdy), 64'd1);
    dout_rdy = 1'b1;

    // Streaming: three bundles back to back
    @(posedge clk);
    #1;
    load(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
         64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004);
    @(negedge clk);
    check("stream_first_rdy", 64'(din_rdy), 64'd1);
    @(posedge clk);
    #1;
    load(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
         64'h9999_AAAA_BBBB_CCCC, 64'h0DDD_EEEE_FFFF_0000);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("stream_vld", 64'(dout_vld), 64'd1);
      check("stream_idx", 64'(dout_idx), 64'(k % 4));
      check("stream_rdy", 64'(din_rdy), 64'((k % 4) == 3));
      @(posedge clk);
      #1;
      if (k == 3)
        load(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
             64'hFEDC_BA98_7654_3210, 64'h7FFF_FFFF_FFFF_FFFF);
      if (k == 7) din_vld = 1'b0;
    end
    @(negedge clk);
    check("stream_drained_vld", 64'(dout_vld), 64'd0);

    // Backpressure at beat 2, then last-beat stall with the next bundle waiting
    @(posedge clk);
    #1;
    load(64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
         64'hDEAD_0000_0000_0002, 64'h5EAD_0000_0000_0003);
    wait_accept("bp");
    load(64'hBEEF_0000_0000_0010, 64'hBEEF_0000_0000_0011,
         64'hBEEF_0000_0000_0012, 64'h3EEF_0000_0000_0013);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dout_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_vld", 64'(dout_vld), 64'd1);
      check("bp_idx", 64'(dout_idx), 64'd2);
      check("bp_pd", dout_pd, 64'hDEAD_0000_0000_0002);
      check("bp_rdy", 64'(din_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    @(posedge clk);
    #1;
    dout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ls_idx", 64'(dout_idx), 64'd3);
      check("ls_last", 64'(dout_last), 64'd1);
      check("ls_pd", dout_pd, 64'h5EAD_0000_0000_0003);
      check("ls_rdy", 64'(din_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    @(negedge clk);
    check("ls_release_rdy", 64'(din_rdy), 64'd1);
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    @(negedge clk);
    check("ls_new_vld", 64'(dout_vld), 64'd1);
    check("ls_new_idx", 64'(dout_idx), 64'd0);
    check("ls_new_pd", dout_pd, 64'hBEEF_0000_0000_0010);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("ls_drained_vld", 64'(dout_vld), 64'd0);

    // Reset in the middle of a bundle
    @(posedge clk);
    #1;
    load(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
         64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_FFFF);
    wait_accept("mid_rst");
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_idx", 64'(dout_idx), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_vld", 64'(dout_vld), 64'd0);
    check("rst_async_idx", 64'(dout_idx), 64'd0);
    check("rst_async_pd", dout_pd, 64'd0);
    check("rst_async_rdy", 64'(din_rdy), 64'd1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_vld", 64'(dout_vld), 64'd0);
    end

    // Recovery after reset
    @(posedge clk);
    #1;
    load(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
         64'h5A5A_5A5A_5A5A_5A5A, 64'h25A5_A5A5_A5A5_A5A5);
    wait_accept("recover");
    din_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("recover_idle_vld", 64'(dout_vld), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
